load_store_unit: RTL

Memory-side responder to the core's load/store control signals (mreq, mem_write, funct3).
- Accepts one access per instruction and runs a req/ack handshake on the data-memory bus.
- Stalls the core until the access completes.
- Returns byte/half/word load data, aligned and sign- or zero-extended, for the result_src=01 writeback path.
- Sits between the execute/memory stage and data RAM.

---
 rtl/lsu_pkg.sv | 56 +++++
 rtl/load_formatter.sv | 37 +++
 rtl/load_store_unit.sv | 123 ++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states,
// byte-enable bases and access legality / store-lane helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] BE_B = 4'b0001;
  localparam logic [3:0] BE_H = 4'b0011;
  localparam logic [3:0] BE_W = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } lsu_state_e;

  // Unsigned variants exist only for loads; halves/words must be naturally aligned.
  function automatic logic access_ok(input logic we, input logic [2:0] f3,
                                     input logic [1:0] off);
    logic ok;
    case (f3)
      F3_B:    ok = 1'b1;
      F3_BU:   ok = !we;
      F3_H:    ok = !off[0];
      F3_HU:   ok = !we && !off[0];
      F3_W:    ok = (off == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = BE_B << off;
      2'b01:   be = BE_H << off;
      default: be = BE_W;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] lanes;
    case (f3[1:0])
      2'b00:   lanes = {4{wd[7:0]}};
      2'b01:   lanes = {2{wd[15:0]}};
      default: lanes = wd;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/load_formatter.sv
// Selects the addressed byte/half lane of a read word and sign- or zero-extends it.
// Purely combinational, no backpressure.
module load_formatter
  import lsu_pkg::*;
(
  input  logic [31:0] bus_rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] load_data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = bus_rdata[7:0];
    case (offset)
      2'd0:    lane_b = bus_rdata[7:0];
      2'd1:    lane_b = bus_rdata[15:8];
      2'd2:    lane_b = bus_rdata[23:16];
      default: lane_b = bus_rdata[31:24];
    endcase
    lane_h = offset[1] ? bus_rdata[31:16] : bus_rdata[15:0];
  end

  always_comb begin
    load_data = bus_rdata;
    case (funct3)
      F3_B:    load_data = {{24{lane_b[7]}}, lane_b};
      F3_BU:   load_data = {24'd0, lane_b};
      F3_H:    load_data = {{16{lane_h[15]}}, lane_h};
      F3_HU:   load_data = {16'd0, lane_h};
      default: load_data = bus_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one req/ack data-bus access per mreq, stalling the core until DONE.
// Latency >= 3 cycles (request, REQ until bus_ack, DONE); stall holds the core while waiting.
// Optional LSU_TIMEOUT_EN: abandon REQ after TIMEOUT cycles without bus_ack.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mreq,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              stall,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              access_err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata
);

  lsu_state_e  state;
  logic [1:0]  off_q;
  logic [2:0]  f3_q;
  logic [31:0] fmt_data;
  logic        req_ok;
  logic        start;

  assign req_ok = access_ok(mem_write, funct3, addr[1:0]);
  assign start  = (state == IDLE) && mreq && req_ok;
  // Gating with rst_n lets stall fall the instant reset asserts, even with mreq still high.
  assign stall   = rst_n && (start || (state == REQ));
  assign bus_req = (state == REQ);

  load_formatter u_fmt (
    .bus_rdata (bus_rdata),
    .offset    (off_q),
    .funct3    (f3_q),
    .load_data (fmt_data)
  );

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
  logic [CNT_W-1:0] tmo_cnt;
  logic             tmo_hit;
  assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT - 1));
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      off_q       <= 2'd0;
      f3_q        <= 3'd0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      access_err  <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= '0;
      bus_be      <= 4'd0;
      bus_wdata   <= '0;
`ifdef LSU_TIMEOUT_EN
      tmo_cnt     <= '0;
`endif
    end else begin
      rdata_valid <= 1'b0;
      access_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (mreq) begin
            if (req_ok) begin
              state     <= REQ;
              bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
              bus_we    <= mem_write;
              bus_be    <= byte_en(funct3, addr[1:0]);
              bus_wdata <= store_lanes(funct3, wdata);
              off_q     <= addr[1:0];
              f3_q      <= funct3;
`ifdef LSU_TIMEOUT_EN
              tmo_cnt   <= '0;
`endif
            end else begin
              access_err <= 1'b1;
              rdata      <= '0;
            end
          end
        end
        REQ: begin
          if (bus_ack) begin
            state <= DONE;
            if (!bus_we) begin
              rdata       <= fmt_data;
              rdata_valid <= 1'b1;
            end
          end
`ifdef LSU_TIMEOUT_EN
          else if (tmo_hit) begin
            state      <= DONE;
            access_err <= 1'b1;
            rdata      <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        // mreq still high here is the instruction just served; never restart on it.
        default: state <= IDLE;
      endcase
    end
  end

endmodule
